// File: rtl/risc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : risc_pkg                                                   |
// | Description : Shared widths, opcode constants and fetch FSM encoding     |
// |               for the 8-bit RISC CPU.                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package risc_pkg;

    localparam int c_WIDTH_REG = 8;
    localparam int c_OPCODE    = 3;
    localparam int c_ADDR      = c_WIDTH_REG - c_OPCODE;

    localparam logic [c_OPCODE-1:0] c_OP_HLT = 3'd0;
    localparam logic [c_OPCODE-1:0] c_OP_SKZ = 3'd1;
    localparam logic [c_OPCODE-1:0] c_OP_ADD = 3'd2;
    localparam logic [c_OPCODE-1:0] c_OP_AND = 3'd3;
    localparam logic [c_OPCODE-1:0] c_OP_XOR = 3'd4;
    localparam logic [c_OPCODE-1:0] c_OP_LDA = 3'd5;
    localparam logic [c_OPCODE-1:0] c_OP_STO = 3'd6;
    localparam logic [c_OPCODE-1:0] c_OP_JMP = 3'd7;

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/risc_pc_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : risc_pc_counter                                            |
// | Description : ADDR-wide program counter. Load has priority over         |
// |               increment; increment wraps modulo 2^ADDR.                  |
// | Ports       : clk, rst        clock / synchronous active-high reset      |
// |               i_load,i_load_val  load a new PC                           |
// |               i_inc           advance PC by one                          |
// |               o_pc            current PC register                        |
// |               o_pc_nxt        value the PC takes at the next edge        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module risc_pc_counter
    import risc_pkg::*;
#(
    parameter int ADDR = c_ADDR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [ADDR-1:0] i_load_val,
    input  logic            i_inc,
    output logic [ADDR-1:0] o_pc,
    output logic [ADDR-1:0] o_pc_nxt
);

    localparam logic [ADDR-1:0] c_ONE = {{(ADDR-1){1'b0}}, 1'b1};

    logic [ADDR-1:0] r_pc;

    // The fetch FSM needs the post-edge PC to register mem_addr in the
    // same cycle the PC itself updates, so the next value is exported.
    always_comb begin
        o_pc_nxt = r_pc;
        if (i_load) begin
            o_pc_nxt = i_load_val;
        end else if (i_inc) begin
            o_pc_nxt = r_pc + c_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else begin
            r_pc <= o_pc_nxt;
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/risc_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : risc_fetch_unit                                            |
// | Description : Instruction fetch stage. Owns the PC, issues one memory    |
// |               read per instruction, holds the word in the IR and hands   |
// |               it to execute over valid/ready. Execute-stage redirects    |
// |               (halt > branch > skip > sequential) apply at handoff.      |
// | Ports       : clk, reset                 clock / sync active-high reset  |
// |               mem_rd_req, mem_addr       read strobe / address (out)     |
// |               mem_rd_data, mem_rd_valid  read return (in)                |
// |               ir_valid, ir_ready         IR handshake                    |
// |               ir_opcode, ir_operand, ir_pc  held instruction (out)       |
// |               branch_en, branch_target, skip_en, halt  redirects (in)    |
// |               pc_out, halted             status (out)                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module risc_fetch_unit
    import risc_pkg::*;
#(
    parameter int WIDTH_REG = c_WIDTH_REG,
    parameter int OPCODE    = c_OPCODE,
    parameter int ADDR      = WIDTH_REG - OPCODE
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 mem_rd_req,
    output logic [ADDR-1:0]      mem_addr,
    input  logic [WIDTH_REG-1:0] mem_rd_data,
    input  logic                 mem_rd_valid,
    output logic                 ir_valid,
    input  logic                 ir_ready,
    output logic [OPCODE-1:0]    ir_opcode,
    output logic [ADDR-1:0]      ir_operand,
    output logic [ADDR-1:0]      ir_pc,
    input  logic                 branch_en,
    input  logic [ADDR-1:0]      branch_target,
    input  logic                 skip_en,
    input  logic                 halt,
    output logic [ADDR-1:0]      pc_out,
    output logic                 halted
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic                 r_mem_rd_req;
    logic [ADDR-1:0]      r_mem_addr;
    logic                 r_ir_valid;
    logic [OPCODE-1:0]    r_ir_opcode;
    logic [ADDR-1:0]      r_ir_operand;
    logic [ADDR-1:0]      r_ir_pc;
    logic                 r_halted;

    logic                 w_accept;
    logic                 w_handoff;
    logic                 w_pc_load;
    logic                 w_pc_inc;
    logic [ADDR-1:0]      w_pc;
    logic [ADDR-1:0]      w_pc_nxt;

    assign w_accept  = (r_state == ST_WAIT) && mem_rd_valid;
    assign w_handoff = (r_state == ST_HOLD) && ir_ready;

    // Redirect priority at handoff: halt freezes the PC, branch loads,
    // skip steps past the following word. Sequential needs no PC change
    // because the PC was already advanced when the word was accepted.
    assign w_pc_load = w_handoff && !halt && branch_en;
    assign w_pc_inc  = w_accept || (w_handoff && !halt && !branch_en && skip_en);

    risc_pc_counter #(
        .ADDR (ADDR)
    ) u_pc (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_pc_load),
        .i_load_val (branch_target),
        .i_inc      (w_pc_inc),
        .o_pc       (w_pc),
        .o_pc_nxt   (w_pc_nxt)
    );

    // Outputs are registered from the next state, so the request strobe is
    // high exactly during the REQ cycle. Out of reset the strobe is still
    // low, so REQ lingers one cycle to raise it before moving to WAIT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_REQ: begin
                if (r_mem_rd_req) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rd_valid) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ir_ready) begin
                    w_state_nxt = halt ? ST_HALTED : ST_REQ;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_REQ;
            r_mem_rd_req <= 1'b0;
            r_mem_addr   <= '0;
            r_ir_valid   <= 1'b0;
            r_ir_opcode  <= '0;
            r_ir_operand <= '0;
            r_ir_pc      <= '0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_rd_req <= (w_state_nxt == ST_REQ);
            r_ir_valid   <= (w_state_nxt == ST_HOLD);
            r_halted     <= (w_state_nxt == ST_HALTED);
            if (w_state_nxt == ST_REQ) begin
                r_mem_addr <= w_pc_nxt;
            end
            if (w_accept) begin
                r_ir_opcode  <= mem_rd_data[WIDTH_REG-1 -: OPCODE];
                r_ir_operand <= mem_rd_data[ADDR-1:0];
                r_ir_pc      <= w_pc;
            end
        end
    end

    assign mem_rd_req = r_mem_rd_req;
    assign mem_addr   = r_mem_addr;
    assign ir_valid   = r_ir_valid;
    assign ir_opcode  = r_ir_opcode;
    assign ir_operand = r_ir_operand;
    assign ir_pc      = r_ir_pc;
    assign pc_out     = w_pc;
    assign halted     = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_risc_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_risc_fetch_unit                                         |
// | Description : Directed self-checking bench for risc_fetch_unit. Inputs   |
// |               are driven and outputs sampled on the falling edge.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_risc_fetch_unit;

    logic       clk;
    logic       reset;
    logic       mem_rd_req;
    logic [4:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_rd_valid;
    logic       ir_valid;
    logic       ir_ready;
    logic [2:0] ir_opcode;
    logic [4:0] ir_operand;
    logic [4:0] ir_pc;
    logic       branch_en;
    logic [4:0] branch_target;
    logic       skip_en;
    logic       halt;
    logic [4:0] pc_out;
    logic       halted;

    int n_checks = 0;
    int n_fail   = 0;

    risc_fetch_unit u_dut (
        .clk           (clk),
        .reset         (reset),
        .mem_rd_req    (mem_rd_req),
        .mem_addr      (mem_addr),
        .mem_rd_data   (mem_rd_data),
        .mem_rd_valid  (mem_rd_valid),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .ir_opcode     (ir_opcode),
        .ir_operand    (ir_operand),
        .ir_pc         (ir_pc),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .skip_en       (skip_en),
        .halt          (halt),
        .pc_out        (pc_out),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Serve one read: wait for the strobe, return data after lat cycles and
    // check the IR that results. wait_br pulses branch_en during WAIT.
    task automatic fetch(input int lat, input logic [7:0] data,
                         input logic [4:0] exp_addr, input bit wait_br);
        int         n;
        logic [4:0] nx;
        logic [2:0] op;
        logic [4:0] opd;
        n = 0;
        while (!mem_rd_req && n < 20) begin
            tick();
            n++;
        end
        chk_eq("req_seen", 32'(mem_rd_req), 32'd1);
        chk_eq("req_addr", 32'(mem_addr), 32'(exp_addr));
        tick();
        chk_eq("req_one_cycle", 32'(mem_rd_req), 32'd0);
        for (int i = 1; i < lat; i++) begin
            if (wait_br) begin
                branch_en     = 1'b1;
                branch_target = 5'h0A;
            end
            tick();
            chk_eq("wait_no_req", 32'(mem_rd_req), 32'd0);
            chk_eq("wait_no_ir", 32'(ir_valid), 32'd0);
        end
        branch_en     = 1'b0;
        branch_target = 5'h00;
        mem_rd_valid  = 1'b1;
        mem_rd_data   = data;
        tick();
        mem_rd_valid  = 1'b0;
        mem_rd_data   = 8'h00;
        nx  = exp_addr + 5'd1;
        op  = data[7:5];
        opd = data[4:0];
        chk_eq("ir_valid", 32'(ir_valid), 32'd1);
        chk_eq("ir_opcode", 32'(ir_opcode), 32'(op));
        chk_eq("ir_operand", 32'(ir_operand), 32'(opd));
        chk_eq("ir_pc", 32'(ir_pc), 32'(exp_addr));
        chk_eq("pc_after_load", 32'(pc_out), 32'(nx));
    endtask

    task automatic handoff(input bit br, input logic [4:0] tgt, input bit sk,
                           input bit hl, input logic [4:0] exp_addr);
        ir_ready      = 1'b1;
        branch_en     = br;
        branch_target = tgt;
        skip_en       = sk;
        halt          = hl;
        tick();
        ir_ready      = 1'b0;
        branch_en     = 1'b0;
        branch_target = 5'h00;
        skip_en       = 1'b0;
        halt          = 1'b0;
        chk_eq("ho_ir_valid", 32'(ir_valid), 32'd0);
        chk_eq("ho_pc", 32'(pc_out), 32'(exp_addr));
        if (hl) begin
            chk_eq("ho_halted", 32'(halted), 32'd1);
            chk_eq("ho_halt_no_req", 32'(mem_rd_req), 32'd0);
        end else begin
            chk_eq("ho_req", 32'(mem_rd_req), 32'd1);
            chk_eq("ho_addr", 32'(mem_addr), 32'(exp_addr));
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk_eq({tag, "_pc"}, 32'(pc_out), 32'd0);
        chk_eq({tag, "_ir_valid"}, 32'(ir_valid), 32'd0);
        chk_eq({tag, "_ir_opcode"}, 32'(ir_opcode), 32'd0);
        chk_eq({tag, "_ir_operand"}, 32'(ir_operand), 32'd0);
        chk_eq({tag, "_ir_pc"}, 32'(ir_pc), 32'd0);
        chk_eq({tag, "_req"}, 32'(mem_rd_req), 32'd0);
        chk_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk_eq({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        int reqs;
        reset         = 1'b1;
        mem_rd_data   = 8'h00;
        mem_rd_valid  = 1'b0;
        ir_ready      = 1'b0;
        branch_en     = 1'b0;
        branch_target = 5'h00;
        skip_en       = 1'b0;
        halt          = 1'b0;

        // Reset and first fetch
        tick();
        tick();
        chk_reset_state("rst");
        reset = 1'b0;
        tick();
        chk_eq("req_after_rst", 32'(mem_rd_req), 32'd1);
        chk_eq("addr_after_rst", 32'(mem_addr), 32'd0);
        fetch(1, 8'hA3, 5'd0, 1'b0);

        // Backpressure on the first instruction
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_eq("bp_valid", 32'(ir_valid), 32'd1);
            chk_eq("bp_opcode", 32'(ir_opcode), 32'd5);
            chk_eq("bp_operand", 32'(ir_operand), 32'h03);
            chk_eq("bp_ir_pc", 32'(ir_pc), 32'd0);
            chk_eq("bp_no_req", 32'(mem_rd_req), 32'd0);
            chk_eq("bp_pc_out", 32'(pc_out), 32'd1);
        end
        handoff(1'b0, 5'h00, 1'b0, 1'b0, 5'd1);

        // Branch beats skip; branch pulse in WAIT is ignored
        fetch(1, 8'hE5, 5'd1, 1'b0);
        handoff(1'b1, 5'h1C, 1'b1, 1'b0, 5'h1C);
        fetch(2, 8'h9F, 5'h1C, 1'b1);
        handoff(1'b0, 5'h00, 1'b0, 1'b0, 5'h1D);

        // Skip from 4 -> 6
        fetch(1, 8'hE4, 5'h1D, 1'b0);
        handoff(1'b1, 5'd4, 1'b0, 1'b0, 5'd4);
        fetch(1, 8'h21, 5'd4, 1'b0);
        handoff(1'b0, 5'h00, 1'b1, 1'b0, 5'd6);

        // Skip wrap from 30 -> 0 and from 31 -> 1
        fetch(1, 8'hFE, 5'd6, 1'b0);
        handoff(1'b1, 5'd30, 1'b0, 1'b0, 5'd30);
        fetch(1, 8'h20, 5'd30, 1'b0);
        handoff(1'b0, 5'h00, 1'b1, 1'b0, 5'd0);
        fetch(1, 8'hFF, 5'd0, 1'b0);
        handoff(1'b1, 5'd31, 1'b0, 1'b0, 5'd31);
        fetch(1, 8'h20, 5'd31, 1'b0);
        handoff(1'b0, 5'h00, 1'b1, 1'b0, 5'd1);

        // Sequential wrap from 31 -> 0
        fetch(1, 8'hFF, 5'd1, 1'b0);
        handoff(1'b1, 5'd31, 1'b0, 1'b0, 5'd31);
        fetch(1, 8'h40, 5'd31, 1'b0);
        handoff(1'b0, 5'h00, 1'b0, 1'b0, 5'd0);

        // Memory wait states, then a spurious valid while holding
        fetch(5, 8'h5A, 5'd0, 1'b0);
        mem_rd_valid = 1'b1;
        mem_rd_data  = 8'hFF;
        tick();
        mem_rd_valid = 1'b0;
        mem_rd_data  = 8'h00;
        chk_eq("spur_opcode", 32'(ir_opcode), 32'd2);
        chk_eq("spur_operand", 32'(ir_operand), 32'h1A);
        chk_eq("spur_ir_pc", 32'(ir_pc), 32'd0);
        chk_eq("spur_valid", 32'(ir_valid), 32'd1);
        chk_eq("spur_pc_out", 32'(pc_out), 32'd1);
        handoff(1'b0, 5'h00, 1'b0, 1'b0, 5'd1);

        // Halt beats branch and skip; PC stays at 2
        fetch(1, 8'h00, 5'd1, 1'b0);
        handoff(1'b1, 5'h10, 1'b1, 1'b1, 5'd2);
        reqs = 0;
        ir_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            mem_rd_valid = i[0];
            tick();
            if (mem_rd_req) reqs++;
        end
        ir_ready     = 1'b0;
        mem_rd_valid = 1'b0;
        chk_eq("halt_req_count", 32'(reqs), 32'd0);
        chk_eq("halt_sticky", 32'(halted), 32'd1);
        chk_eq("halt_ir_valid", 32'(ir_valid), 32'd0);
        chk_eq("halt_pc", 32'(pc_out), 32'd2);

        // Fresh run, then reset mid-WAIT with a colliding read return
        reset = 1'b1;
        tick();
        tick();
        chk_reset_state("rst2");
        reset = 1'b0;
        tick();
        fetch(1, 8'h61, 5'd0, 1'b0);
        handoff(1'b0, 5'h00, 1'b0, 1'b0, 5'd1);
        tick();
        chk_eq("midwait_no_req", 32'(mem_rd_req), 32'd0);
        reset        = 1'b1;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 8'hFF;
        tick();
        mem_rd_valid = 1'b0;
        mem_rd_data  = 8'h00;
        chk_reset_state("rst3");
        reset = 1'b0;
        tick();
        chk_eq("req_after_rst3", 32'(mem_rd_req), 32'd1);
        chk_eq("addr_after_rst3", 32'(mem_addr), 32'd0);
        fetch(1, 8'hC7, 5'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
